// File: rtl/gpr_access_arb_if.sv
// Debug/bus requester port of the GPR access arbiter: req/gnt accept, one-cycle rvalid response.
interface gpr_access_arb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/gpr_access_arb.sv
// Shares the GPR write port and bus read port between core write-back (always wins)
// and a single-outstanding debug requester, with starvation relief via stall_o.
module gpr_access_arb #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_waddr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              stall_o,
  gpr_access_arb_if.slave   dbg,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i
);

  localparam int                CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_STALL  = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, PEND, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              addr_bad;
  logic              addr_zero;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] rd_value;
  logic              slot;

  assign addr_bad  = {1'b0, addr_q} >= NUM_REGS_W;
  assign addr_zero = (addr_q == '0);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // A core write to the same register in the read cycle is newer than the file contents.
  assign rd_value = addr_zero                                 ? '0 :
                    (core_we_i && core_waddr_i == addr_q)     ? core_wdata_i :
                                                                rf_rdata_i;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    slot    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dbg.req) begin
          we_d    = dbg.we;
          addr_d  = dbg.addr;
          wdata_d = dbg.wdata;
          state_d = PEND;
        end
      end
      PEND: begin
        if (addr_bad || !we_q || !core_we_i) begin
          slot    = we_q && !addr_bad;
          rdata_d = (addr_bad || we_q) ? '0 : rd_value;
          err_d   = addr_bad;
          cnt_d   = '0;
          stall_d = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_inc;
          stall_d = stall_q || (cnt_inc >= CNT_STALL);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Core has absolute priority on the write port; x0 core writes pass through untouched.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = addr_q;
    rf_wdata_o = wdata_q;
    if (core_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = core_waddr_i;
      rf_wdata_o = core_wdata_i;
    end else if (slot && !addr_zero) begin
      rf_we_o    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rf_raddr_o = addr_q;
  assign stall_o    = stall_q;
  assign dbg.gnt    = (state_q == IDLE);
  assign dbg.rvalid = (state_q == RESP);
  assign dbg.rdata  = rdata_q;
  assign dbg.err    = err_q;

endmodule

// File: tb/tb_gpr_access_arb.sv
// Directed bench for gpr_access_arb: transaction-level model plus hand-computed literals.
module tb_gpr_access_arb;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              core_we = 1'b0;
  logic [ADDR_W-1:0] core_waddr = '0;
  logic [DATA_W-1:0] core_wdata = '0;
  logic              stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;

  gpr_access_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

  gpr_access_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .stall_o(stall), .dbg(dbg_if),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata)
  );

  always #5 clk = ~clk;

  // GPR file the arbiter drives
  logic [DATA_W-1:0] regs [32];
  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;
  assign rf_rdata = regs[rf_raddr];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: 0 = free, 1 = request held, 2 = answering
  int                ph = 0, n_ph = 0;
  logic              t_we = 1'b0, n_we = 1'b0;
  logic [ADDR_W-1:0] t_addr = '0, n_addr = '0;
  logic [DATA_W-1:0] t_wdata = '0, n_wdata = '0;
  int                m_blocked = 0, n_blocked = 0;
  logic [DATA_W-1:0] m_rdata = '0, n_rdata = '0;
  logic              m_err = 1'b0, n_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt", dbg_if.gnt, 1'b1);
      check("rst_rvalid", dbg_if.rvalid, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_rdata", dbg_if.rdata, 32'h0);
      check("rst_err", dbg_if.err, 1'b0);
      ph = 0; m_blocked = 0; m_rdata = '0; m_err = 1'b0;
      n_ph = 0; n_blocked = 0; n_rdata = '0; n_err = 1'b0;
    end else begin
      logic              dbg_slot;
      logic              e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      dbg_slot = (ph == 1) && t_we && (int'(t_addr) < NUM_REGS) && !core_we;
      e_we   = core_we || (dbg_slot && t_addr != 0);
      e_addr = core_we ? core_waddr : t_addr;
      e_data = core_we ? core_wdata : t_wdata;
      check("gnt", dbg_if.gnt, ph == 0);
      check("rvalid", dbg_if.rvalid, ph == 2);
      check("rdata", dbg_if.rdata, m_rdata);
      check("err", dbg_if.err, m_err);
      check("stall", stall, (ph == 1) && (m_blocked >= MAX_WAIT - 1));
      check("rf_we", rf_we, e_we);
      if (e_we) begin
        check("rf_waddr", rf_waddr, e_addr);
        check("rf_wdata", rf_wdata, e_data);
      end
      n_ph = ph; n_we = t_we; n_addr = t_addr; n_wdata = t_wdata;
      n_blocked = m_blocked; n_rdata = m_rdata; n_err = m_err;
      if (ph == 0) begin
        if (dbg_if.req) begin
          n_ph = 1; n_we = dbg_if.we; n_addr = dbg_if.addr; n_wdata = dbg_if.wdata; n_blocked = 0;
        end
      end else if (ph == 1) begin
        if (int'(t_addr) >= NUM_REGS) begin
          n_ph = 2; n_rdata = '0; n_err = 1'b1;
        end else if (!t_we) begin
          n_ph = 2; n_err = 1'b0;
          if (t_addr == 0) n_rdata = '0;
          else if (core_we && core_waddr == t_addr) n_rdata = core_wdata;
          else n_rdata = regs[t_addr];
        end else if (!core_we) begin
          n_ph = 2; n_rdata = '0; n_err = 1'b0;
        end else begin
          n_blocked = m_blocked + 1;
        end
      end else begin
        n_ph = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      ph = n_ph; t_we = n_we; t_addr = n_addr; t_wdata = n_wdata;
      m_blocked = n_blocked; m_rdata = n_rdata; m_err = n_err;
    end
  end

  task automatic core_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    core_we = 1'b1; core_waddr = a; core_wdata = d;
    @(posedge clk); #1;
    core_we = 1'b0;
  endtask

  // Issue a request from a post-edge point; returns with the bench one cycle after the response.
  task automatic do_txn(input string name, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd, output logic er);
    int  lat;
    bit  found;
    dbg_if.req = 1'b1; dbg_if.we = w; dbg_if.addr = a; dbg_if.wdata = d;
    @(posedge clk); #1;
    dbg_if.req = 1'b0;
    lat = 1; found = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dbg_if.rvalid) begin found = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_responded"}, found, 1'b1);
    if (found) begin
      rd = dbg_if.rdata; er = dbg_if.err;
      check({name, "_latency"}, lat, 2);
    end
    @(posedge clk); #1;
  endtask

  logic [DATA_W-1:0] rd;
  logic              er;

  initial begin
    dbg_if.req = 1'b0; dbg_if.we = 1'b0; dbg_if.addr = '0; dbg_if.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    core_write(5'd5, 32'h1234);
    core_write(5'd9, 32'h0909);
    core_write(5'd0, 32'h0055);
    core_write(5'd4, 32'h0404);

    do_txn("rd_x5", 1'b0, 5'd5, '0, rd, er);
    check("rd_x5_data", rd, 32'h1234);
    check("rd_x5_err", er, 1'b0);

    // Forwarding: core writes x5 during the read cycle
    dbg_if.req = 1'b1; dbg_if.we = 1'b0; dbg_if.addr = 5'd5;
    @(posedge clk); #1;
    dbg_if.req = 1'b0;
    core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hBEEF;
    @(posedge clk); #1;
    core_we = 1'b0;
    @(negedge clk);
    check("fwd_rvalid", dbg_if.rvalid, 1'b1);
    check("fwd_rdata", dbg_if.rdata, 32'hBEEF);
    check("fwd_regfile", regs[5], 32'hBEEF);
    @(posedge clk); #1;

    do_txn("wr_x10", 1'b1, 5'd10, 32'h77, rd, er);
    check("wr_x10_rdata", rd, 32'h0);
    check("wr_x10_regfile", regs[10], 32'h77);

    // Starvation: core holds write-back for 20 cycles
    core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'h3333;
    dbg_if.req = 1'b1; dbg_if.we = 1'b1; dbg_if.addr = 5'd7; dbg_if.wdata = 32'hA5A5;
    @(posedge clk); #1;
    dbg_if.req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 7) check("stall_before_7", stall, 1'b0);
      if (k == 8) begin
        check("stall_after_7", stall, 1'b1);
        check("core_wins_addr", rf_waddr, 5'd3);
      end
      @(posedge clk); #1;
    end
    core_we = 1'b0;
    @(negedge clk);
    check("slot_we", rf_we, 1'b1);
    check("slot_addr", rf_waddr, 5'd7);
    check("slot_data", rf_wdata, 32'hA5A5);
    @(posedge clk); #1;
    @(negedge clk);
    check("starve_rvalid", dbg_if.rvalid, 1'b1);
    check("starve_stall_clr", stall, 1'b0);
    check("starve_regfile", regs[7], 32'hA5A5);
    @(posedge clk); #1;

    do_txn("rd_x20", 1'b0, 5'd20, '0, rd, er);
    check("rd_x20_err", er, 1'b1);
    check("rd_x20_rdata", rd, 32'h0);
    do_txn("wr_x20", 1'b1, 5'd20, 32'hDEAD, rd, er);
    check("wr_x20_err", er, 1'b1);
    check("wr_x20_alias", regs[4], 32'h0404);

    do_txn("wr_x0", 1'b1, 5'd0, 32'hFFFF, rd, er);
    check("wr_x0_err", er, 1'b0);
    check("wr_x0_regfile", regs[0], 32'h0055);
    do_txn("rd_x0", 1'b0, 5'd0, '0, rd, er);
    check("rd_x0_data", rd, 32'h0);

    // Reset while a write to x9 is blocked with stall raised
    core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'h3131;
    dbg_if.req = 1'b1; dbg_if.we = 1'b1; dbg_if.addr = 5'd9; dbg_if.wdata = 32'h9999;
    @(posedge clk); #1;
    dbg_if.req = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre_rst_stall", stall, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_stall_async", stall, 1'b0);
    check("rst_gnt_async", dbg_if.gnt, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    core_we = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("rst_no_write", regs[9], 32'h0909);

    do_txn("rd_x9", 1'b0, 5'd9, '0, rd, er);
    check("rd_x9_data", rd, 32'h0909);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
